flash_cmd_sequencer: RTL

- Bus initiator toward the parallel NOR flash: issues JEDEC command write sequences (word program, sector erase, chip erase, read/reset) and supervises completion via FLASH_BUSY_n.
- Sits between the accelerator's control-register logic (command source) and the flash pins.
- Owns FLASH_WE_n/CE_n/DQ drive only while a command runs; idle it releases the bus so the CPU read path keeps it.

---
 rtl/flash_cmd_sequencer_if.sv | 30 +++
 rtl/flash_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer_if.sv
// Command request bus plus NOR flash pin bundle seen by flash_cmd_sequencer.
// master = command source / flash side, slave = the sequencer.
interface flash_cmd_sequencer_if;
    logic        CMD_VALID;
    logic [1:0]  CMD;
    logic [18:0] CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_READY;
    logic        DONE;
    logic        ERROR;
    logic        ACTIVE;
    logic        FLASH_BUSY_n;
    logic [18:0] FLASH_A;
    logic [15:0] FLASH_DQ_OUT;
    logic        FLASH_DQ_OE;
    logic        FLASH_CE_n;
    logic        FLASH_WE_n;

    modport master (
        output CMD_VALID, CMD, CMD_ADDR, CMD_DATA, FLASH_BUSY_n,
        input  CMD_READY, DONE, ERROR, ACTIVE,
        input  FLASH_A, FLASH_DQ_OUT, FLASH_DQ_OE, FLASH_CE_n, FLASH_WE_n
    );

    modport slave (
        input  CMD_VALID, CMD, CMD_ADDR, CMD_DATA, FLASH_BUSY_n,
        output CMD_READY, DONE, ERROR, ACTIVE,
        output FLASH_A, FLASH_DQ_OUT, FLASH_DQ_OE, FLASH_CE_n, FLASH_WE_n
    );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command-write sequencer for the parallel NOR flash: issues the unlock and
// command write cycles, then supervises completion through RY/BY#.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | bus released, CMD_READY high, waiting for a command
// S_W_SETUP | CE_n low, address/data driven, WE_n high
// S_W_LOW   | WE_n low (write strobe)
// S_W_HOLD  | WE_n high again, address/data/CE_n held
// S_SETTLE  | bus released, give the flash time to assert busy
// S_POLL    | wait for synchronized BUSY_n high or timeout
// S_FINISH  | one-cycle DONE pulse, then back to idle
module flash_cmd_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned WE_CYC      = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic                 CLKCPU,
    input  logic                 RESET_n,
    flash_cmd_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_LOW,
        S_W_HOLD,
        S_SETTLE,
        S_POLL,
        S_FINISH
    } state_t;

    localparam logic [1:0]  CMD_PROG  = 2'd0;
    localparam logic [1:0]  CMD_SECT  = 2'd1;
    localparam logic [1:0]  CMD_RST   = 2'd3;
    localparam logic [18:0] ADDR_555  = 19'h00555;
    localparam logic [18:0] ADDR_2AA  = 19'h002AA;
    localparam logic [15:0] CNT_SETUP = 16'(SETUP_CYC - 1);
    localparam logic [15:0] CNT_WE    = 16'(WE_CYC - 1);
    localparam logic [15:0] CNT_HOLD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] CNT_SETL  = 16'(SETTLE_CYC - 1);
    localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYC - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [23:0] tcnt, tcnt_nx;
    logic [2:0]  step, step_nx;
    logic [2:0]  last_step;
    logic [1:0]  cmd_q, cmd_nx;
    logic [18:0] addr_q, addr_nx;
    logic [15:0] data_q, data_nx;
    logic        error_q, error_nx;
    logic [18:0] fa_q, fa_nx;
    logic [15:0] fd_q, fd_nx;
    logic        busy_meta, busy_sync;
    logic        drive_nx;
    logic        ready_q, done_q, active_q, ce_n_q, we_n_q, oe_q;

    // {address, data} of write cycle s for command c
    function automatic logic [34:0] step_word(input logic [1:0]  c,
                                              input logic [2:0]  s,
                                              input logic [18:0] a,
                                              input logic [15:0] d);
        logic [34:0] w;
        w = {ADDR_555, 16'h00AA};
        if (c == CMD_RST) begin
            w = {a, 16'h00F0};
        end else if (c == CMD_PROG) begin
            case (s)
                3'd0:    w = {ADDR_555, 16'h00AA};
                3'd1:    w = {ADDR_2AA, 16'h0055};
                3'd2:    w = {ADDR_555, 16'h00A0};
                default: w = {a, d};
            endcase
        end else begin
            case (s)
                3'd0:    w = {ADDR_555, 16'h00AA};
                3'd1:    w = {ADDR_2AA, 16'h0055};
                3'd2:    w = {ADDR_555, 16'h0080};
                3'd3:    w = {ADDR_555, 16'h00AA};
                3'd4:    w = {ADDR_2AA, 16'h0055};
                default: w = (c == CMD_SECT) ? {a, 16'h0030} : {ADDR_555, 16'h0010};
            endcase
        end
        return w;
    endfunction

    assign last_step = (cmd_q == CMD_RST)  ? 3'd0 :
                       (cmd_q == CMD_PROG) ? 3'd3 : 3'd5;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        step_nx  = step;
        cmd_nx   = cmd_q;
        addr_nx  = addr_q;
        data_nx  = data_q;
        error_nx = error_q;
        fa_nx    = fa_q;
        fd_nx    = fd_q;
        case (state)
            S_IDLE: begin
                if (bus.CMD_VALID) begin
                    state_nx = S_W_SETUP;
                    cmd_nx   = bus.CMD;
                    addr_nx  = bus.CMD_ADDR;
                    data_nx  = bus.CMD_DATA;
                    error_nx = 1'b0;
                    step_nx  = 3'd0;
                    cnt_nx   = CNT_SETUP;
                end
            end
            S_W_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_W_LOW;
                    cnt_nx   = CNT_WE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            S_W_LOW: begin
                if (cnt == '0) begin
                    state_nx = S_W_HOLD;
                    cnt_nx   = CNT_HOLD;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            S_W_HOLD: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 16'd1;
                end else if (step != last_step) begin
                    state_nx = S_W_SETUP;
                    step_nx  = step + 3'd1;
                    cnt_nx   = CNT_SETUP;
                end else if (cmd_q == CMD_RST) begin
                    state_nx = S_FINISH;
                end else begin
                    state_nx = S_SETTLE;
                    cnt_nx   = CNT_SETL;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nx = S_POLL;
                    tcnt_nx  = '0;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            S_POLL: begin
                // ready is tested first so it wins over a coincident timeout
                if (busy_sync) begin
                    state_nx = S_FINISH;
                end else if (tcnt == TMO_LAST) begin
                    state_nx = S_FINISH;
                    error_nx = 1'b1;
                end else begin
                    tcnt_nx = tcnt + 24'd1;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (state_nx == S_W_SETUP) begin
            {fa_nx, fd_nx} = step_word(cmd_nx, step_nx, addr_nx, data_nx);
        end
        drive_nx = (state_nx == S_W_SETUP) || (state_nx == S_W_LOW) || (state_nx == S_W_HOLD);
    end

    always_ff @(posedge CLKCPU) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            step      <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            fa_q      <= '0;
            fd_q      <= '0;
            busy_meta <= 1'b1;
            busy_sync <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tcnt      <= tcnt_nx;
            step      <= step_nx;
            cmd_q     <= cmd_nx;
            addr_q    <= addr_nx;
            data_q    <= data_nx;
            error_q   <= error_nx;
            fa_q      <= fa_nx;
            fd_q      <= fd_nx;
            busy_meta <= bus.FLASH_BUSY_n;
            busy_sync <= busy_meta;
            ready_q   <= (state_nx == S_IDLE);
            done_q    <= (state_nx == S_FINISH);
            active_q  <= (state_nx != S_IDLE) && (state_nx != S_FINISH);
            ce_n_q    <= !drive_nx;
            we_n_q    <= (state_nx != S_W_LOW);
            oe_q      <= drive_nx;
        end
    end

    assign bus.CMD_READY    = ready_q;
    assign bus.DONE         = done_q;
    assign bus.ERROR        = error_q;
    assign bus.ACTIVE       = active_q;
    assign bus.FLASH_A      = fa_q;
    assign bus.FLASH_DQ_OUT = fd_q;
    assign bus.FLASH_DQ_OE  = oe_q;
    assign bus.FLASH_CE_n   = ce_n_q;
    assign bus.FLASH_WE_n   = we_n_q;

endmodule
